map_blitter: RTL and testbench

Framebuffer writer for the main-game screen. On a start pulse from the game FSM it walks every pixel of the 320×240 framebuffer in raster order, looks up the map tile under that pixel (camera-offset, wrapping), fetches the tile texel and writes it into framebuffer RAM, one pixel per clock. It is the write-side counterpart of the frame drawer, which reads the same framebuffer for VGA output.

---
 rtl/map_blit_pkg.sv | 22 ++
 rtl/blit_raster_counter.sv | 46 ++++
 rtl/map_blitter.sv | 165 ++++++++++++++++
 tb/tb_map_blitter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/map_blit_pkg.sv
// Shared definitions for the main-game framebuffer writer and the frame drawer.
package map_blit_pkg;

    localparam int unsigned DEF_FB_W    = 320;
    localparam int unsigned DEF_FB_H    = 240;
    localparam int unsigned DEF_MAP_W_T = 64;
    localparam int unsigned DEF_MAP_H_T = 64;
    localparam int unsigned DEF_TILE    = 16;

    // Cycles spent flushing the fetch pipeline after the last pixel is issued.
    localparam int unsigned DRAIN_CYCLES = 3;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } blit_state_e;

endpackage

// File: rtl/blit_raster_counter.sv
// Raster-order x/y pixel counter with end-of-frame flag and linear framebuffer address.
module blit_raster_counter
    import map_blit_pkg::*;
#(
    parameter int unsigned FB_W = DEF_FB_W,
    parameter int unsigned FB_H = DEF_FB_H,
    parameter int unsigned XW   = $clog2(FB_W),
    parameter int unsigned YW   = $clog2(FB_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [18:0]   addr,
    output logic          last
);

    logic x_wrap;

    assign x_wrap = (x == XW'(FB_W - 1));
    assign last   = x_wrap && (y == YW'(FB_H - 1));

    // addr tracks y*FB_W + x incrementally, so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (step) begin
            addr <= last ? '0 : addr + 19'd1;
            if (x_wrap) begin
                x <= '0;
                y <= (y == YW'(FB_H - 1)) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/map_blitter.sv
// Walks the framebuffer in raster order, fetches the camera-offset map tile texel for each
// pixel through a 3-stage ROM pipeline and writes it, one pixel per clock.
module map_blitter
    import map_blit_pkg::*;
#(
    parameter int unsigned FB_W    = DEF_FB_W,
    parameter int unsigned FB_H    = DEF_FB_H,
    parameter int unsigned MAP_W_T = DEF_MAP_W_T,
    parameter int unsigned MAP_H_T = DEF_MAP_H_T,
    parameter int unsigned TILE    = DEF_TILE
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  cam_x,
    input  logic [9:0]  cam_y,
    output logic        busy,
    output logic        done,
    output logic [11:0] map_addr,
    input  logic [7:0]  map_data,
    output logic [15:0] tile_addr,
    input  logic [23:0] tile_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [23:0] fb_data
);

    localparam int unsigned XW   = $clog2(FB_W);
    localparam int unsigned YW   = $clog2(FB_H);
    localparam int unsigned MX_W = $clog2(MAP_W_T * TILE);
    localparam int unsigned MY_W = $clog2(MAP_H_T * TILE);
    localparam int unsigned TB   = $clog2(TILE);

    blit_state_e state;
    logic [1:0]  drain_cnt;
    logic [9:0]  cam_x_q;
    logic [9:0]  cam_y_q;
    logic        busy_q;
    logic        done_q;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [18:0]   lin;
    logic          last;
    logic          issue;

    logic [MX_W-1:0] mx;
    logic [MY_W-1:0] my;

    logic            s1_valid;
    logic [2*TB-1:0] s1_tex;
    logic [18:0]     s1_addr;
    logic            s2_valid;
    logic [18:0]     s2_addr;
    logic            fb_we_q;
    logic [18:0]     fb_addr_q;
    rgb_t            fb_data_q;

    assign issue = (state == StRun);

    blit_raster_counter #(
        .FB_W (FB_W),
        .FB_H (FB_H),
        .XW   (XW),
        .YW   (YW)
    ) u_counter (
        .clk   (Clk),
        .rst_n (Reset),
        .clear (state == StIdle),
        .step  (issue),
        .x     (x),
        .y     (y),
        .addr  (lin),
        .last  (last)
    );

    // Map wrap is plain truncation because the map is a power of two in pixels.
    assign mx = MX_W'(cam_x_q + 10'(x));
    assign my = MY_W'(cam_y_q + 10'(y));

    assign map_addr  = issue ? {my[MY_W-1:TB], mx[MX_W-1:TB]} : '0;
    assign tile_addr = s1_valid ? {map_data, s1_tex} : '0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= StIdle;
            drain_cnt <= '0;
            cam_x_q   <= '0;
            cam_y_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state  <= StIdle;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            cam_x_q <= cam_x;
                            cam_y_q <= cam_y;
                            busy_q  <= 1'b1;
                            state   <= StRun;
                        end
                    end
                    StRun: begin
                        if (last) begin
                            drain_cnt <= '0;
                            state     <= StDrain;
                        end
                    end
                    StDrain: begin
                        if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= StFin;
                        end else begin
                            drain_cnt <= drain_cnt + 2'd1;
                        end
                    end
                    StFin: state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

    // Stage 1 waits for map_data, stage 2 for tile_data, then the write is registered.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_valid  <= 1'b0;
            s1_tex    <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else if (abort) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            fb_we_q  <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_tex   <= {my[TB-1:0], mx[TB-1:0]};
            s1_addr  <= lin;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            fb_we_q  <= s2_valid;
            if (s2_valid) begin
                fb_addr_q <= s2_addr;
                fb_data_q <= tile_data;
            end
        end
    end

endmodule

// File: tb/tb_map_blitter.sv
// Randomized scoreboard bench for map_blitter on a reduced 40x24 frame; expected pixels
// come from a direct pixel-to-texel model of the camera/map/tile lookup.
module tb_map_blitter;

    localparam int W = 40;
    localparam int H = 24;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  cam_x;
    logic [9:0]  cam_y;
    logic        busy;
    logic        done;
    logic [11:0] map_addr;
    logic [7:0]  map_data;
    logic [15:0] tile_addr;
    logic [23:0] tile_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;

    logic [18:0] exp_addr[$];
    logic [23:0] exp_data[$];

    always #5 clk = ~clk;

    map_blitter #(
        .FB_W (W),
        .FB_H (H)
    ) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .start     (start),
        .abort     (abort),
        .cam_x     (cam_x),
        .cam_y     (cam_y),
        .busy      (busy),
        .done      (done),
        .map_addr  (map_addr),
        .map_data  (map_data),
        .tile_addr (tile_addr),
        .tile_data (tile_data),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data)
    );

    function automatic logic [7:0] map_fn(int unsigned a);
        if (mode == 0) return a[7:0];
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    function automatic logic [23:0] tex_fn(int unsigned a);
        if (mode == 0) return {a[15:8], 4'h0, a[7:4], 4'h0, a[3:0]};
        return 24'((a * 32'd2654435761) ^ (a >> 5));
    endfunction

    // Synchronous ROMs: data one cycle after address.
    always @(posedge clk) begin
        map_data  <= map_fn(32'(map_addr));
        tile_data <= tex_fn(32'(tile_addr));
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    endtask

    task automatic push_blit(int cx, int cy, int count);
        for (int p = 0; p < count; p++) begin
            int unsigned px  = p % W;
            int unsigned py  = p / W;
            int unsigned mx  = (cx + px) % 1024;
            int unsigned my  = (cy + py) % 1024;
            int unsigned tid = map_fn((my / 16) * 64 + mx / 16);
            exp_addr.push_back(19'(p));
            exp_data.push_back(tex_fn(tid * 256 + (my % 16) * 16 + (mx % 16)));
        end
    endtask

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                check("sb_underflow", 32'(exp_addr.size()), 32'd1);
            end else begin
                logic [18:0] ea;
                logic [23:0] ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                check("fb_addr", 32'(fb_addr), 32'(ea));
                check("fb_data", 32'(fb_data), 32'(ed));
                if (mode == 0 && ea == 19'd17) check("px17_data", 32'(fb_data), 32'h010001);
            end
        end
    end

    task automatic check_outputs_zero(string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_fb_data"}, 32'(fb_data), 32'd0);
        check({tag, "_map_addr"}, 32'(map_addr), 32'd0);
        check({tag, "_tile_addr"}, 32'(tile_addr), 32'd0);
    endtask

    // kind: 0 full blit, 1 abort in cycle `at`, 2 reset in cycle `at`, 3 full with start held
    task automatic blit(int cx, int cy, int kind, int at);
        int first_c  = -1;
        int last_c   = -1;
        int wc       = 0;
        int done_n   = 0;
        int done_c   = -1;
        int busy_err = 0;
        int nexp;
        int bound;
        int busy_end;
        int pk;
        int unsigned pmx;
        int unsigned pmy;
        int unsigned pma;

        cam_x = 10'(cx);
        cam_y = 10'(cy);
        start = 1'b1;
        abort = 1'b0;
        nexp  = (kind == 1) ? at - 2 : (kind == 2) ? at - 3 : N;
        bound = (kind == 1) ? at + 1 : (kind == 2) ? at : (kind == 3) ? N + 4 : N + 5;
        busy_end = (kind == 1) ? at : N + 2;
        push_blit(cx, cy, nexp);
        pk  = 10 * W + 5;
        pmx = (cx + 5) % 1024;
        pmy = (cy + 10) % 1024;
        pma = (pmy / 16) * 64 + pmx / 16;

        @(posedge clk);
        #1;
        for (int c = 0; c <= bound; c++) begin
            if (kind != 3) start = 1'b0;
            if (c >= 1) begin
                cam_x = 10'($urandom_range(0, 1023));
                cam_y = 10'($urandom_range(0, 1023));
            end
            abort = (kind == 1 && c == at);
            if (kind == 2 && c == at) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero("async_rst");
                break;
            end
            @(negedge clk);
            if (fb_we) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                wc++;
            end
            if (done) begin
                done_n++;
                done_c = c;
            end
            if (busy !== (c <= busy_end)) busy_err++;
            if ((kind == 0 || kind == 3) && c == pk)
                check("probe_map_addr", 32'(map_addr), 32'(pma));
            if ((kind == 0 || kind == 3) && c == pk + 1)
                check("probe_tile_addr", 32'(tile_addr),
                      32'({map_fn(pma), 4'(pmy % 16), 4'(pmx % 16)}));
            if (c < bound) begin
                @(posedge clk);
                #1;
            end
        end
        abort = 1'b0;

        check("first_we_cycle", 32'(first_c), 32'd3);
        check("write_count", 32'(wc), 32'(nexp));
        check("busy_profile_errs", 32'(busy_err), 32'd0);
        if (kind == 0 || kind == 3) begin
            check("last_we_cycle", 32'(last_c), 32'(N + 2));
            check("done_count", 32'(done_n), 32'd1);
            check("done_cycle", 32'(done_c), 32'(N + 3));
        end else begin
            check("no_done_pulse", 32'(done_n), 32'd0);
            if (kind == 1) check("last_we_before_abort", 32'(last_c), 32'(at));
        end
    endtask

    initial begin
        int idle_we;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cam_x = '0;
        cam_y = '0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        mode = 0;
        blit(0, 0, 0, 0);
        mode = 1;
        blit(1020, 1015, 0, 0);
        blit(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1, 500);
        blit(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 3, 0);
        blit(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 0);
        blit(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 2, 300);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        idle_we = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fb_we || busy) idle_we++;
        end
        check("idle_after_reset", 32'(idle_we), 32'd0);
        check("sb_empty_after_reset", 32'(exp_addr.size()), 32'd0);

        blit(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 0);
        repeat (4) @(negedge clk);
        check("sb_empty_final", 32'(exp_addr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
